// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Memory-mapped 8N1 UART transmitter fed by a small byte FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        i_CLK,
    input  logic        i_RESET_n,
    input  logic [7:0]  i_Data,
    input  logic        i_Write_EN,
    output logic        o_TX,
    output logic        o_Full,
    output logic        o_Busy,
    output logic [15:0] o_Status
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_BW = $clog2(CLKS_PER_BIT);

    localparam logic [c_CW-1:0] c_DEPTH     = c_CW'(FIFO_DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE   = c_AW'(1);
    localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(CLKS_PER_BIT - 1);
    localparam logic [c_BW-1:0] c_BAUD_ONE  = c_BW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [c_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CW-1:0] count_q,  count_d;
    logic            full_q,   full_d;
    state_t          state_q,  state_d;
    logic [c_BW-1:0] baud_q,   baud_d;
    logic [2:0]      idx_q,    idx_d;
    logic [7:0]      sh_q,     sh_d;
    logic            tx_q,     tx_d;

    logic w_push;
    logic w_pop;
    logic w_nonempty;
    logic w_baud_last;

    // Full is taken from the registered flag, so a same-edge pop never frees room.
    assign w_push      = i_Write_EN & ~full_q;
    assign w_nonempty  = (count_q != '0);
    assign w_baud_last = (baud_q == c_BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        w_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (w_nonempty) begin
                    w_pop   = 1'b1;
                    sh_d    = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_last) begin
                    baud_d  = '0;
                    idx_d   = 3'd0;
                    tx_d    = sh_q[0];
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + c_BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (w_baud_last) begin
                    baud_d = '0;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = sh_q[idx_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + c_BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (w_baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (w_nonempty) begin
                        w_pop   = 1'b1;
                        sh_d    = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + c_BAUD_ONE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = w_push ? (wr_ptr_q + c_PTR_ONE) : wr_ptr_q;
        rd_ptr_d = w_pop  ? (rd_ptr_q + c_PTR_ONE) : rd_ptr_q;
        count_d  = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d = (count_d == c_DEPTH);
    end

    always_ff @(posedge i_CLK) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= i_Data;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            idx_q    <= 3'd0;
            sh_q     <= 8'd0;
            tx_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            idx_q    <= idx_d;
            sh_q     <= sh_d;
            tx_q     <= tx_d;
        end
    end

    assign o_TX     = tx_q;
    assign o_Full   = full_q;
    assign o_Busy   = w_nonempty | (state_q != ST_IDLE);
    assign o_Status = {14'b0, o_Busy, o_Full};

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Directed bench for uart_tx_fifo with a line decoder and scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  din   = 8'h00;
    logic        we    = 1'b0;
    logic        o_tx;
    logic        o_full;
    logic        o_busy;
    logic [15:0] o_status;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int start_prev = -1;
    int start_last = -1;
    logic [7:0] exp_q [$];

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_CLK      (clk),
        .i_RESET_n  (rst_n),
        .i_Data     (din),
        .i_Write_EN (we),
        .o_TX       (o_tx),
        .o_Full     (o_full),
        .o_Busy     (o_busy),
        .o_Status   (o_status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Line decoder: samples each bit mid-period and checks against the scoreboard.
    logic       mon_active = 1'b0;
    int         mon_cnt    = 0;
    logic [7:0] mon_byte   = 8'h00;
    logic [7:0] mon_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (o_tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                start_prev = start_last;
                start_last = cyc;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == CPB/2) chk("start_bit", 32'(o_tx), 32'd0);
            for (int i = 0; i < 8; i++)
                if (mon_cnt == CPB*(i+1) + CPB/2) mon_byte[i] = o_tx;
            if (mon_cnt == 9*CPB + CPB/2) chk("stop_bit", 32'(o_tx), 32'd1);
            if (mon_cnt == 10*CPB - 1) begin
                mon_active = 1'b0;
                chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    chk("frame_byte", 32'(mon_byte), 32'(mon_exp));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int lows;

        #1 rst_n = 1'b0;
        #2;
        chk("reset_tx",     32'(o_tx),     32'd1);
        chk("reset_full",   32'(o_full),   32'd0);
        chk("reset_busy",   32'(o_busy),   32'd0);
        chk("reset_status", 32'(o_status), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single frame of 0xA5, cycle by cycle
        b = 8'hA5;
        din = b; we = 1'b1; exp_q.push_back(b);
        @(negedge clk);
        we = 1'b0;
        chk("a5_tx_before_pop", 32'(o_tx),     32'd1);
        chk("a5_status_queued", 32'(o_status), 32'h0002);
        @(negedge clk);
        for (int c = 0; c < 10*CPB; c++) begin
            logic exp_bit;
            if (c < CPB)            exp_bit = 1'b0;
            else if (c < 9*CPB)     exp_bit = b[(c - CPB) / CPB];
            else                    exp_bit = 1'b1;
            chk("a5_line", 32'(o_tx), 32'(exp_bit));
            chk("a5_busy", 32'(o_busy), 32'd1);
            if (c == 5*CPB) chk("a5_status_tx", 32'(o_status), 32'h0002);
            @(negedge clk);
        end
        chk("a5_idle_busy",   32'(o_busy),   32'd0);
        chk("a5_idle_tx",     32'(o_tx),     32'd1);
        chk("a5_idle_status", 32'(o_status), 32'h0000);

        // Back-to-back frames 0x00, 0xFF
        din = 8'h00; we = 1'b1; exp_q.push_back(8'h00);
        @(negedge clk);
        din = 8'hFF; exp_q.push_back(8'hFF);
        @(negedge clk);
        we = 1'b0;
        for (int k = 0; k < 200 && o_busy; k++) @(negedge clk);
        chk("b2b_drain_busy", 32'(o_busy), 32'd0);
        chk("b2b_gap", 32'(start_last - start_prev), 32'(10*CPB));
        chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        // Overfill: 0x10 to shifter, 0x11..0x14 queued, 0x15 dropped
        for (int i = 0; i < 6; i++) begin
            din = 8'h10 + 8'(i); we = 1'b1;
            if (i < 5) exp_q.push_back(8'h10 + 8'(i));
            @(negedge clk);
        end
        we = 1'b0;
        chk("ovf_full",   32'(o_full),   32'd1);
        chk("ovf_status", 32'(o_status), 32'h0003);
        repeat (35) @(negedge clk);
        din = 8'h77; we = 1'b1;
        chk("pop_edge_full_before", 32'(o_full), 32'd1);
        @(negedge clk);
        we = 1'b0;
        chk("pop_edge_full_after", 32'(o_full),   32'd0);
        chk("pop_edge_status",     32'(o_status), 32'h0002);
        din = 8'h20; we = 1'b1; exp_q.push_back(8'h20);
        @(negedge clk);
        we = 1'b0;
        chk("count_three_refill", 32'(o_full), 32'd1);
        for (int k = 0; k < 400 && o_busy; k++) @(negedge clk);
        chk("ovf_drain_busy",   32'(o_busy),       32'd0);
        chk("ovf_queue_empty",  32'(exp_q.size()), 32'd0);

        // Reset mid-DATA of 0x3C with two bytes queued
        din = 8'h3C; we = 1'b1; exp_q.push_back(8'h3C);
        @(negedge clk);
        din = 8'h55; exp_q.push_back(8'h55);
        @(negedge clk);
        din = 8'h66; exp_q.push_back(8'h66);
        @(negedge clk);
        we = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_reset_tx_low", 32'(o_tx), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_tx",   32'(o_tx),   32'd1);
        chk("async_reset_busy", 32'(o_busy), 32'd0);
        chk("async_reset_full", 32'(o_full), 32'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (o_tx !== 1'b1) lows++;
        end
        chk("post_reset_tx_quiet", 32'(lows),     32'd0);
        chk("post_reset_busy",     32'(o_busy),   32'd0);
        chk("post_reset_full",     32'(o_full),   32'd0);
        chk("post_reset_status",   32'(o_status), 32'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Memory-mapped UART transmitter peripheral, the write-side counterpart to the receive path in the memory map. The CPU writes a byte to the TX data address. The byte is pushed into a small FIFO, then serialized onto o_TX as 8N1, LSB first. The memory decoder drives i_Write_EN from the address select ANDed with the CPU write strobe, and reads back o_Status through the read mux.

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200 baud); must be >= 2
FIFO_DEPTH, 16, number of byte entries; must be a power of 2, >= 2

Ports:
i_CLK  input  1  system clock; all state changes on its rising edge
i_RESET_n  input  1  reset, asynchronous assert, active-low
i_Data  input  8  byte to transmit (decoder passes the CPU data bus [7:0])
i_Write_EN  input  1  push strobe; one push per cycle it is high
o_TX  output  1  serial line; idle high
o_Full  output  1  FIFO holds FIFO_DEPTH entries
o_Busy  output  1  FIFO non-empty OR a frame in progress
o_Status  output  16  {14'b0, o_Busy, o_Full}, for the read mux

Behaviour:
- Reset (asynchronous, while i_RESET_n=0):
  - o_TX=1, o_Full=0, o_Busy=0
  - FIFO pointers and count = 0; FSM = IDLE; baud counter = 0; bit index = 0
  - Reset asserted mid-frame aborts the frame immediately; o_TX goes high without waiting for a clock edge.
  - Queued bytes are discarded.
- FIFO push:
  - On a rising edge with i_Write_EN=1 and o_Full=0, i_Data is written at the write pointer and the write pointer increments, wrapping modulo FIFO_DEPTH.
  - A write while o_Full=1 is silently dropped; no pointer or count change.
  - o_Full is evaluated before any same-edge pop. A write on the edge where a full FIFO pops is still dropped.
- FIFO pop:
  - Performed only by the FSM, only when the FIFO is non-empty.
  - A simultaneous push and pop on a non-full FIFO leaves the count unchanged and both pointers advance.
- Count and flags:
  - Count width is clog2(FIFO_DEPTH)+1.
  - o_Full = (count==FIFO_DEPTH), registered with the count.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: o_TX=1. If the FIFO is non-empty: pop the head into shift register sh[7:0], clear the baud counter, go to START.
  - START: o_TX=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: o_TX=sh[index] for CLKS_PER_BIT cycles each. Index 0..7, LSB first. After index 7 completes, go to STOP.
  - STOP: o_TX=1 for CLKS_PER_BIT cycles. At the final cycle of STOP:
    - if the FIFO is non-empty: pop the next byte and go directly to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- o_TX is registered, so there are no combinational glitches.
- Latency: a push at edge N makes the FIFO non-empty after N. The IDLE FSM pops at edge N+1, and o_TX falls after edge N+1. The start bit occupies cycles N+1 .. N+CLKS_PER_BIT.
- Frame length is exactly 10*CLKS_PER_BIT cycles, measured from the o_TX falling edge to the end of the stop bit.
- Baud counter counts 0..CLKS_PER_BIT-1 and resets on each bit boundary. No counter wrap affects framing.
- o_Busy:
  - registered/combinational from (count!=0) | (state!=IDLE);
  - high from the cycle after the first accepted push until the cycle after the last stop bit ends with an empty FIFO.
- The FIFO holds up to FIFO_DEPTH bytes queued, plus 1 byte in the shift register.

Test Plan:
- Set CLKS_PER_BIT=4. Reset, then push 0xA5 once:
  - o_TX is low 4 cycles starting 1 cycle after the push;
  - then bits 1,0,1,0,0,1,0,1, each 4 cycles;
  - then high 4 cycles;
  - o_Busy=1 throughout and 0 after.
- Push 0x00 then 0xFF on consecutive cycles:
  - frame 2's start bit begins exactly 40 cycles after frame 1's start bit, with no idle cycle;
  - decoded bytes are 0x00, 0xFF.
- FIFO_DEPTH=4, CLKS_PER_BIT=4. Push 0x10..0x15 on 6 consecutive cycles:
  - 0x10 goes to the shift register; 0x11..0x14 are queued and o_Full=1;
  - 0x15 is dropped;
  - the line carries 0x10,0x11,0x12,0x13,0x14 only.
- Full FIFO with a pop on the same edge as a write of 0x77:
  - 0x77 is dropped;
  - o_Full deasserts the next cycle; count = 3.
- Assert i_RESET_n=0 mid-DATA of 0x3C with 2 bytes queued:
  - o_TX=1 during reset, before any clock edge;
  - after release: o_Busy=0, o_Full=0, o_TX stays high with no further frames.
- o_Status readback:
  - 0x0000 idle;
  - 0x0002 while transmitting a single byte;
  - 0x0003 when full.
